// File: rtl/alu_issue.sv
// ALU issue stage: decodes an RV32I register-read bundle into ALU controls
// and operands, buffered by a two-entry skid buffer.
module alu_issue #(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_op,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic            out_b_negate,
    output logic            out_b_add_one,
    output logic            out_sign,
    output logic            out_illegal
);

    typedef struct packed {
        logic [2:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            neg;
        logic            add1;
        logic            sign;
        logic            ill;
    } bundle_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic            unused;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = XLEN'($signed(in_instr[31:20]));
    assign imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign shamt  = XLEN'(in_instr[24:20]);
    assign unused = ^in_instr[19:15];

    bundle_t dec;
    bundle_t main_q;
    bundle_t skid_q;
    logic    main_valid;
    logic    skid_valid;
    logic    ill;

    always_comb begin
        dec = '0;
        ill = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                dec.a  = in_rs1;
                dec.b  = in_rs2;
                dec.op = f3;
                if (f7 == F7_ZERO) begin
                    ill = 1'b0;
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    dec.neg  = 1'b1;
                    dec.add1 = 1'b1;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    dec.sign = 1'b1;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                dec.a  = in_rs1;
                dec.b  = imm_i;
                dec.op = f3;
                if (f3 == 3'b001) begin
                    dec.b = shamt;
                    ill   = (f7 != F7_ZERO);
                end else if (f3 == 3'b101) begin
                    dec.b    = shamt;
                    dec.sign = (f7 == F7_ALT);
                    ill      = (f7 != F7_ZERO) && (f7 != F7_ALT);
                end
            end
            OPC_LUI: begin
                dec.b = imm_u;
            end
            OPC_AUIPC: begin
                dec.a = in_pc;
                dec.b = imm_u;
            end
            OPC_LOAD: begin
                dec.a = in_rs1;
                dec.b = imm_i;
            end
            OPC_STORE: begin
                dec.a = in_rs1;
                dec.b = imm_s;
            end
            OPC_BRANCH: begin
                dec.a = in_rs1;
                dec.b = in_rs2;
                unique case (f3[2:1])
                    2'b00: begin
                        dec.neg  = 1'b1;
                        dec.add1 = 1'b1;
                    end
                    2'b10:   dec.op = 3'b010;
                    2'b11:   dec.op = 3'b011;
                    default: ill = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                dec.a = in_pc;
                dec.b = XLEN'(PC_STEP);
                ill   = (opcode == OPC_JALR) && (f3 != 3'b000);
            end
            default: ill = 1'b1;
        endcase
        // Illegal bundles carry zeroed ALU fields so downstream sees a no-op add.
        if (ill) begin
            dec     = '0;
            dec.ill = 1'b1;
        end
    end

    logic accept;
    logic load_main;

    assign accept    = in_valid && in_ready;
    assign load_main = !main_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (load_main) begin
                main_valid <= skid_valid || accept;
                if (skid_valid) begin
                    main_q <= skid_q;
                end else if (accept) begin
                    main_q <= dec;
                end
            end
            if (skid_valid && load_main) begin
                skid_valid <= 1'b0;
            end else if (accept && !load_main) begin
                skid_valid <= 1'b1;
                skid_q     <= dec;
            end
        end
    end

    assign in_ready      = !skid_valid;
    assign out_valid     = main_valid;
    assign out_op        = main_q.op;
    assign out_a         = main_q.a;
    assign out_b         = main_q.b;
    assign out_b_negate  = main_q.neg;
    assign out_b_add_one = main_q.add1;
    assign out_sign      = main_q.sign;
    assign out_illegal   = main_q.ill;

endmodule
